// File: rtl/vec_wb_sequencer_if.sv
// Vector result handshake and element write-back bus between the vector
// datapath, the write-back sequencer and the register-file bank demux.
interface vec_wb_sequencer_if #(
  parameter int data_width_p = 32,
  parameter int els_p        = 16,
  parameter int num_banks_p  = 4,
  parameter int num_regs_p   = 8
);
  localparam int sel_w        = $clog2(num_banks_p);
  localparam int rows_per_reg = els_p / num_banks_p;
  localparam int addr_w       = $clog2(num_regs_p * rows_per_reg);
  localparam int vl_w         = $clog2(els_p + 1);
  localparam int reg_w        = $clog2(num_regs_p);

  logic                          v_i;
  logic                          ready_o;
  logic [reg_w-1:0]              reg_i;
  logic [vl_w-1:0]               vl_i;
  logic [els_p*data_width_p-1:0] data_i;
  logic                          wr_v_o;
  logic [sel_w-1:0]              wr_sel_o;
  logic [addr_w-1:0]             wr_addr_o;
  logic [data_width_p-1:0]       wr_data_o;
  logic                          stall_i;
  logic                          done_o;

  modport master (
    output v_i, reg_i, vl_i, data_i, stall_i,
    input  ready_o, wr_v_o, wr_sel_o, wr_addr_o, wr_data_o, done_o
  );

  modport slave (
    input  v_i, reg_i, vl_i, data_i, stall_i,
    output ready_o, wr_v_o, wr_sel_o, wr_addr_o, wr_data_o, done_o
  );
endinterface

// File: rtl/vec_wb_sequencer.sv
// Write-back sequencer: captures one vector result per handshake and emits one
// bank/row/element write per accepted cycle, pulsing done_o after the last one.
module vec_wb_sequencer #(
  parameter int data_width_p = 32,
  parameter int els_p        = 16,
  parameter int num_banks_p  = 4,
  parameter int num_regs_p   = 8
) (
  input logic               clk_i,
  input logic               reset_n_i,
  vec_wb_sequencer_if.slave bus
);
  localparam int sel_w        = $clog2(num_banks_p);
  localparam int rows_per_reg = els_p / num_banks_p;
  localparam int addr_w       = $clog2(num_regs_p * rows_per_reg);
  localparam int vl_w         = $clog2(els_p + 1);
  localparam int reg_w        = $clog2(num_regs_p);
  localparam int idx_w        = $clog2(els_p);

  localparam logic [0:0] state_idle  = 1'b0;
  localparam logic [0:0] state_write = 1'b1;

  localparam logic [vl_w-1:0] vl_max = vl_w'(els_p);

  logic [0:0]              state;
  logic [vl_w-1:0]         idx;
  logic [vl_w-1:0]         len;
  logic [vl_w-1:0]         vl_clamped;
  logic [vl_w-1:0]         row;
  logic [reg_w-1:0]        reg_r;
  logic [data_width_p-1:0] buffer [els_p];
  logic                    done_r;
  logic                    accept;
  logic                    wr_accept;

  assign vl_clamped = (bus.vl_i > vl_max) ? vl_max : bus.vl_i;
  assign accept     = bus.v_i && (state == state_idle);
  assign wr_accept  = (state == state_write) && !bus.stall_i;
  assign row        = idx >> sel_w;

  // done_r defaults low each edge so it can only ever be a one-cycle pulse
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= state_idle;
      idx    <= '0;
      len    <= '0;
      reg_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        state_idle: begin
          if (accept) begin
            reg_r <= bus.reg_i;
            len   <= vl_clamped;
            idx   <= '0;
            if (vl_clamped == '0) begin
              done_r <= 1'b1;
            end else begin
              state <= state_write;
            end
          end
        end
        state_write: begin
          if (wr_accept) begin
            idx <= idx + vl_w'(1);
            if (idx == len - vl_w'(1)) begin
              state  <= state_idle;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= state_idle;
      endcase
    end
  end

  // The element buffer carries no reset; it is only read while in WRITE
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < els_p; i++) begin
        buffer[i] <= bus.data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  always_comb begin
    bus.ready_o   = (state == state_idle);
    bus.wr_v_o    = 1'b0;
    bus.wr_sel_o  = '0;
    bus.wr_addr_o = '0;
    bus.wr_data_o = '0;
    if (state == state_write) begin
      bus.wr_v_o    = 1'b1;
      bus.wr_sel_o  = idx[sel_w-1:0];
      bus.wr_addr_o = addr_w'(reg_r) * addr_w'(rows_per_reg) + addr_w'(row);
      bus.wr_data_o = buffer[idx[idx_w-1:0]];
    end
  end

  assign bus.done_o = done_r;
endmodule

// File: tb/tb_vec_wb_sequencer.sv
// Self-checking bench for vec_wb_sequencer: table-driven vectors, hand-written
// corner sequences and randomized vectors against a transaction-level model.
module tb_vec_wb_sequencer;
  localparam int dataWidth  = 32;
  localparam int els        = 16;
  localparam int numBanks   = 4;
  localparam int numRegs    = 8;
  localparam int rowsPerReg = els / numBanks;
  localparam int dataBits   = els * dataWidth;

  typedef struct {
    logic [2:0]  r;
    logic [4:0]  vl;
    logic [31:0] base;
    logic [63:0] stallMask;
    int          expWrites;
    logic [4:0]  expFirstAddr;
    logic [4:0]  expLastAddr;
    logic [1:0]  expLastSel;
    logic [31:0] expLastData;
  } vec_rec_t;

  logic clk;
  logic rstN;
  int   checkCount;
  int   passCount;

  vec_wb_sequencer_if #(
    .data_width_p(dataWidth), .els_p(els), .num_banks_p(numBanks), .num_regs_p(numRegs)
  ) bus ();

  vec_wb_sequencer #(
    .data_width_p(dataWidth), .els_p(els), .num_banks_p(numBanks), .num_regs_p(numRegs)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rstN),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clampLen(input logic [4:0] vl);
    return (int'(vl) > els) ? els : int'(vl);
  endfunction

  // Element i of a vector lands in bank i mod numBanks at row reg*rowsPerReg + i/numBanks
  function automatic logic [39:0] expectedWrite(input logic [2:0] r, input logic [dataBits-1:0] d, input int i);
    logic [1:0] sel;
    logic [4:0] addr;
    sel  = 2'(i % numBanks);
    addr = 5'(int'(r) * rowsPerReg + i / numBanks);
    return {1'b1, sel, addr, d[i*dataWidth +: dataWidth]};
  endfunction

  function automatic logic [dataBits-1:0] makeData(input logic [31:0] base);
    logic [dataBits-1:0] d;
    for (int i = 0; i < els; i++) d[i*dataWidth +: dataWidth] = base + 32'(i);
    return d;
  endfunction

  function automatic logic [dataBits-1:0] randData();
    logic [dataBits-1:0] d;
    for (int i = 0; i < els; i++) d[i*dataWidth +: dataWidth] = $urandom;
    return d;
  endfunction

  task automatic scrambleInputs();
    bus.v_i    = 1'b0;
    bus.reg_i  = 3'($urandom);
    bus.vl_i   = 5'($urandom);
    bus.data_i = randData();
  endtask

  // Called at a falling edge while idle; returns at the falling edge of the first cycle after acceptance
  task automatic applyStimulus(input logic [2:0] r, input logic [4:0] vl, input logic [dataBits-1:0] d);
    checkOutput("ready_idle", {bus.ready_o, bus.wr_v_o}, 2'b10);
    bus.reg_i  = r;
    bus.vl_i   = vl;
    bus.data_i = d;
    bus.v_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walks the expected write list cycle by cycle, then checks the done cycle
  task automatic drainVector(input logic [2:0] r, input logic [4:0] vl, input logic [dataBits-1:0] d,
                             input logic [63:0] stallMask, input bit randStall, input int stopAt,
                             output int nWrites, output logic [4:0] firstAddr, output logic [4:0] lastAddr,
                             output logic [1:0] lastSel, output logic [31:0] lastData);
    int len;
    int k;
    int cyc;
    bit stall;
    len = clampLen(vl);
    k = 0;
    cyc = 0;
    nWrites = 0;
    firstAddr = '0;
    lastAddr = '0;
    lastSel = '0;
    lastData = '0;
    while (k < len && k != stopAt && cyc < 500) begin
      checkOutput("write", {24'd0, bus.wr_v_o, bus.wr_sel_o, bus.wr_addr_o, bus.wr_data_o}, {24'd0, expectedWrite(r, d, k)});
      checkOutput("busy_flags", {bus.ready_o, bus.done_o}, 2'b00);
      stall = ((cyc < 64) ? stallMask[cyc] : 1'b0) | (randStall && $urandom_range(0, 2) == 0);
      bus.stall_i = stall;
      if (!stall && bus.wr_v_o === 1'b1) begin
        if (nWrites == 0) firstAddr = bus.wr_addr_o;
        lastAddr = bus.wr_addr_o;
        lastSel  = bus.wr_sel_o;
        lastData = bus.wr_data_o;
        nWrites++;
      end
      @(posedge clk);
      @(negedge clk);
      if (!stall) k++;
      cyc++;
    end
    bus.stall_i = 1'b0;
    if (k < len && k != stopAt) checkOutput("drain_bound", 64'(k), 64'(len));
    if (k == len) begin
      checkOutput("done_cycle",
                  {22'd0, bus.ready_o, bus.done_o, bus.wr_v_o, bus.wr_sel_o, bus.wr_addr_o, bus.wr_data_o},
                  {22'd0, 1'b1, 1'b1, 1'b0, 2'b0, 5'b0, 32'b0});
    end
  endtask

  task automatic checkPulseEnd(input string name);
    @(posedge clk);
    @(negedge clk);
    checkOutput(name, {bus.done_o, bus.wr_v_o, bus.ready_o}, 3'b001);
  endtask

  vec_rec_t tbl [6];

  initial begin
    logic [dataBits-1:0] d;
    logic [dataBits-1:0] dB;
    int          nW;
    logic [4:0]  fa;
    logic [4:0]  la;
    logic [1:0]  ls;
    logic [31:0] ld;

    checkCount = 0;
    passCount  = 0;
    tbl[0] = '{3'd3, 5'd6,  32'hA0,  64'h0, 6,  5'd12, 5'd13, 2'd1, 32'hA5};
    tbl[1] = '{3'd3, 5'd6,  32'hA0,  64'h6, 6,  5'd12, 5'd13, 2'd1, 32'hA5};
    tbl[2] = '{3'd7, 5'd16, 32'h100, 64'h0, 16, 5'd28, 5'd31, 2'd3, 32'h10F};
    tbl[3] = '{3'd0, 5'd31, 32'h200, 64'h0, 16, 5'd0,  5'd3,  2'd3, 32'h20F};
    tbl[4] = '{3'd5, 5'd0,  32'h300, 64'h0, 0,  5'd0,  5'd0,  2'd0, 32'h0};
    tbl[5] = '{3'd4, 5'd17, 32'h400, 64'h5, 16, 5'd16, 5'd19, 2'd3, 32'h40F};

    rstN = 1'b0;
    bus.v_i = 1'b0;
    bus.reg_i = '0;
    bus.vl_i = '0;
    bus.data_i = '0;
    bus.stall_i = 1'b0;
    #1;
    checkOutput("reset_outputs",
                {22'd0, bus.ready_o, bus.done_o, bus.wr_v_o, bus.wr_sel_o, bus.wr_addr_o, bus.wr_data_o},
                {22'd0, 1'b1, 1'b0, 1'b0, 2'b0, 5'b0, 32'b0});
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      d = makeData(tbl[t].base);
      applyStimulus(tbl[t].r, tbl[t].vl, d);
      scrambleInputs();
      drainVector(tbl[t].r, tbl[t].vl, d, tbl[t].stallMask, 1'b0, -1, nW, fa, la, ls, ld);
      checkOutput("tbl_writes", 64'(nW), 64'(tbl[t].expWrites));
      checkOutput("tbl_first_addr", 64'(fa), 64'(tbl[t].expFirstAddr));
      checkOutput("tbl_last_addr", 64'(la), 64'(tbl[t].expLastAddr));
      checkOutput("tbl_last_sel", 64'(ls), 64'(tbl[t].expLastSel));
      checkOutput("tbl_last_data", 64'(ld), 64'(tbl[t].expLastData));
      checkPulseEnd("done_pulse");
    end

    // A request held valid through a whole vector is taken on the done edge
    d  = makeData(32'hC0);
    dB = makeData(32'h50);
    applyStimulus(3'd1, 5'd3, d);
    bus.reg_i  = 3'd4;
    bus.vl_i   = 5'd2;
    bus.data_i = dB;
    drainVector(3'd1, 5'd3, d, 64'h0, 1'b0, -1, nW, fa, la, ls, ld);
    checkOutput("hold_a_writes", 64'(nW), 64'd3);
    @(posedge clk);
    @(negedge clk);
    scrambleInputs();
    drainVector(3'd4, 5'd2, dB, 64'h0, 1'b0, -1, nW, fa, la, ls, ld);
    checkOutput("hold_b_first_addr", 64'(fa), 64'd16);
    checkOutput("hold_b_last_data", 64'(ld), 64'h51);
    checkPulseEnd("hold_done_pulse");

    // Reset while element 4 of a ten-element vector is on the bus
    d = makeData(32'h30);
    applyStimulus(3'd2, 5'd10, d);
    scrambleInputs();
    drainVector(3'd2, 5'd10, d, 64'h0, 1'b0, 4, nW, fa, la, ls, ld);
    checkOutput("abort_elem4", {24'd0, bus.wr_v_o, bus.wr_sel_o, bus.wr_addr_o, bus.wr_data_o},
                {24'd0, expectedWrite(3'd2, d, 4)});
    rstN = 1'b0;
    #1;
    checkOutput("abort_immediate", {bus.ready_o, bus.wr_v_o, bus.done_o}, 3'b100);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_no_done", {bus.ready_o, bus.wr_v_o, bus.done_o}, 3'b100);
    d = makeData(32'h60);
    applyStimulus(3'd6, 5'd5, d);
    scrambleInputs();
    drainVector(3'd6, 5'd5, d, 64'h0, 1'b0, -1, nW, fa, la, ls, ld);
    checkOutput("fresh_first_addr", 64'(fa), 64'd24);
    checkPulseEnd("fresh_done_pulse");

    for (int n = 0; n < 30; n++) begin
      logic [2:0] r;
      logic [4:0] vl;
      r  = 3'($urandom_range(0, numRegs - 1));
      vl = 5'($urandom_range(0, 20));
      d  = randData();
      applyStimulus(r, vl, d);
      scrambleInputs();
      drainVector(r, vl, d, 64'h0, 1'b1, -1, nW, fa, la, ls, ld);
      checkOutput("rand_writes", 64'(nW), 64'(clampLen(vl)));
      checkPulseEnd("rand_done_pulse");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/vec_wb_sequencer.md
# vec_wb_sequencer

Write-back sequencer for the vector register file. It accepts one full vector result (up to `els_p` elements) per handshake and serializes it into one element write per cycle. Each write carries a bank select, a row address and the element data, and feeds the bank-select demux directly. It absorbs bank back-pressure and reports completion with a one-cycle pulse.

## Interface
- `data_width_p`, 32: element width in bits.
- `els_p`, 16: maximum vector length. Power of 2, multiple of `num_banks_p`.
- `num_banks_p`, 4: number of register-file banks. Power of 2, at least 2.
- `num_regs_p`, 8: number of architectural vector registers. Power of 2.
- Derived widths:
  - `sel_w = clog2(num_banks_p)`.
  - `rows_per_reg = els_p/num_banks_p`.
  - `addr_w = clog2(num_regs_p*rows_per_reg)`.
  - `vl_w = clog2(els_p+1)`.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset, asynchronous assert, active-low.
- `v_i`  in  1  input vector valid.
- `ready_o`  out  1  block can accept a vector.
- `reg_i`  in  clog2(num_regs_p)  destination vector register.
- `vl_i`  in  vl_w  vector length; values above `els_p` are clamped to `els_p`.
- `data_i`  in  els_p×data_width_p  element array; element 0 is in the LSBs.
- `wr_v_o`  out  1  element write valid.
- `wr_sel_o`  out  sel_w  target bank; drives the demux select.
- `wr_addr_o`  out  addr_w  row address within the bank.
- `wr_data_o`  out  data_width_p  element data; drives the demux input.
- `stall_i`  in  1  banks busy; the presented write is not consumed this cycle.
- `done_o`  out  1  single-cycle pulse marking vector completion.

## Operation
- FSM states are IDLE and WRITE. Registers:
  - `state`
  - `idx` (vl_w bits)
  - `len` (vl_w bits)
  - `reg_r`
  - element buffer, els_p×data_width_p
  - `done_r`
- IDLE:
  - `ready_o=1`.
  - On `v_i & ready_o`, capture `data_i`, `reg_i` and the clamped `vl_i`, and set `idx=0`.
  - If the clamped vl is 0: stay in IDLE and set `done_r=1` (pulse next cycle).
  - Otherwise go to WRITE.
- WRITE:
  - `ready_o=0`; `v_i` is ignored.
  - `wr_v_o=1`.
  - `wr_sel_o = idx mod num_banks_p` (low bits of `idx`).
  - `wr_addr_o = reg_r*rows_per_reg + idx/num_banks_p`.
  - `wr_data_o = buffer[idx]`.
- Write acceptance is `wr_v_o & ~stall_i`:
  - On acceptance, `idx` increments.
  - If `idx==len-1` at acceptance, go to IDLE and set `done_r=1`.
- While `stall_i=1`, `wr_v_o`, `wr_sel_o`, `wr_addr_o`, `wr_data_o` and `idx` stay unchanged. There is no timeout.
- All `wr_*` outputs are decoded combinationally from registered state only; no input-to-output combinational path exists.
- When `wr_v_o=0`, `wr_sel_o`, `wr_addr_o` and `wr_data_o` are driven to 0.
- `done_o = done_r`. `done_r` is cleared on every edge where it is not set.
- Address arithmetic is unsigned. It cannot overflow `addr_w` because `idx < els_p` always holds.

## Timing
- Reset (`reset_n_i=0`, asynchronous):
  - state=IDLE, `idx=0`, `len=0`, `done_r=0`. The buffer is not reset.
  - Outputs immediately: `ready_o=1`, `wr_v_o=0`, `wr_sel_o=0`, `wr_addr_o=0`, `wr_data_o=0`, `done_o=0`.
- Reset mid-WRITE aborts the vector. Remaining elements are dropped and no `done_o` is produced.
- Latency:
  - Handshake accepted at edge N → first write valid in cycle N+1.
  - With no stalls, a vector of length L occupies cycles N+1 … N+L.
  - `done_o` is high in cycle N+L+1, together with `ready_o=1`.
- The next vector can be accepted at the edge ending cycle N+L+1. Throughput is L+1 cycles per vector.
- Each stall cycle adds exactly one cycle to the completion time.
- vl=0: accepted at edge N → `done_o` in cycle N+1. No writes occur, and `ready_o` stays 1.

## Test plan
- Basic sequencing:
  - Stimulus: reset, then `reg_i=3`, `vl_i=6`, `data_i[i]=0xA0+i`, no stall.
  - Required: 6 consecutive writes with sel 0,1,2,3,0,1, addr 12,12,12,12,13,13, data 0xA0..0xA5.
  - Then `done_o` for exactly 1 cycle, in the cycle after the last write.
- Back-pressure:
  - Stimulus: same vector, `stall_i=1` during the 2nd and 3rd write cycles.
  - Required: element 1 (sel 1, addr 12, data 0xA1) is held for 3 cycles, and total time to `done_o` grows by 2. No element is skipped or duplicated.
- Boundaries:
  - Stimulus: `reg_i=7`, `vl_i=16`, then `reg_i=0`, `vl_i=31`.
  - Required for `vl_i=16`: 16 writes, last at addr 31, sel 3.
  - Required for `vl_i=31`: clamped to 16 writes, addr 0..3.
- Zero length and ignored input:
  - Stimulus: `vl_i=0`, then `v_i=1` held throughout a WRITE.
  - Required for `vl_i=0`: `done_o` next cycle, `wr_v_o` never asserted.
  - Required for the WRITE: no capture until `ready_o=1`; the held request is accepted at the `done_o` edge and its first write follows.
- Reset mid-operation:
  - Stimulus: assert `reset_n_i=0` during element 4 of a `vl=10` vector.
  - Required: `wr_v_o=0` and `ready_o=1` immediately, no `done_o`.
  - After release, a fresh vector starts from idx 0.
